// File: rtl/io_port_fifo.sv
// Two independent show-ahead circular FIFOs between one Octavo I/O port pair and its streams.
// Define IO_PORT_FIFO_ERROR_EN to build the sticky illegal-strobe detector behind `error`.
module io_port_fifo #(
  parameter int unsigned WORD_WIDTH = 36,
  parameter int unsigned DEPTH      = 4,
  parameter int unsigned ADDR_WIDTH = 2
) (
  input  logic                  clock,
  input  logic                  reset_n,
  // ingress stream -> CPU read port
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [WORD_WIDTH-1:0] in_data,
  output logic [WORD_WIDTH-1:0] io_read_data,
  output logic                  io_read_EF,
  input  logic                  io_rden,
  // CPU write port -> egress stream
  input  logic [WORD_WIDTH-1:0] io_write_data,
  input  logic                  io_wren,
  output logic                  io_write_EF,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [WORD_WIDTH-1:0] out_data,
  output logic                  error
);

  localparam logic [ADDR_WIDTH:0]   CntFull = (ADDR_WIDTH + 1)'(DEPTH);
  localparam logic [ADDR_WIDTH:0]   CntOne  = (ADDR_WIDTH + 1)'(1);
  localparam logic [ADDR_WIDTH-1:0] PtrOne  = ADDR_WIDTH'(1);

  // ---------------------------------------------------------------------------
  // Ingress FIFO
  // ---------------------------------------------------------------------------
  logic [WORD_WIDTH-1:0] in_mem_q [DEPTH];
  logic [ADDR_WIDTH-1:0] in_wptr_q, in_wptr_d;
  logic [ADDR_WIDTH-1:0] in_rptr_q, in_rptr_d;
  logic [ADDR_WIDTH:0]   in_cnt_q, in_cnt_d;
  logic                  in_push, in_pop;

  // Flags decode only the count register, so no input reaches them combinationally.
  assign in_ready     = (in_cnt_q != CntFull);
  assign io_read_EF   = (in_cnt_q != '0);
  assign io_read_data = in_mem_q[in_rptr_q];

  assign in_push = in_valid & in_ready;
  assign in_pop  = io_rden & io_read_EF;

  always_comb begin
    in_wptr_d = in_wptr_q;
    in_rptr_d = in_rptr_q;
    in_cnt_d  = in_cnt_q;
    if (in_push) begin
      in_wptr_d = in_wptr_q + PtrOne;
    end
    if (in_pop) begin
      in_rptr_d = in_rptr_q + PtrOne;
    end
    case ({in_push, in_pop})
      2'b10:   in_cnt_d = in_cnt_q + CntOne;
      2'b01:   in_cnt_d = in_cnt_q - CntOne;
      default: in_cnt_d = in_cnt_q;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      in_wptr_q <= '0;
      in_rptr_q <= '0;
      in_cnt_q  <= '0;
    end else begin
      in_wptr_q <= in_wptr_d;
      in_rptr_q <= in_rptr_d;
      in_cnt_q  <= in_cnt_d;
    end
  end

  always_ff @(posedge clock) begin
    if (in_push) begin
      in_mem_q[in_wptr_q] <= in_data;
    end
  end

  // ---------------------------------------------------------------------------
  // Egress FIFO
  // ---------------------------------------------------------------------------
  logic [WORD_WIDTH-1:0] eg_mem_q [DEPTH];
  logic [ADDR_WIDTH-1:0] eg_wptr_q, eg_wptr_d;
  logic [ADDR_WIDTH-1:0] eg_rptr_q, eg_rptr_d;
  logic [ADDR_WIDTH:0]   eg_cnt_q, eg_cnt_d;
  logic                  eg_push, eg_pop;

  assign io_write_EF = (eg_cnt_q != CntFull);
  assign out_valid   = (eg_cnt_q != '0);
  assign out_data    = eg_mem_q[eg_rptr_q];

  assign eg_push = io_wren & io_write_EF;
  assign eg_pop  = out_valid & out_ready;

  always_comb begin
    eg_wptr_d = eg_wptr_q;
    eg_rptr_d = eg_rptr_q;
    eg_cnt_d  = eg_cnt_q;
    if (eg_push) begin
      eg_wptr_d = eg_wptr_q + PtrOne;
    end
    if (eg_pop) begin
      eg_rptr_d = eg_rptr_q + PtrOne;
    end
    case ({eg_push, eg_pop})
      2'b10:   eg_cnt_d = eg_cnt_q + CntOne;
      2'b01:   eg_cnt_d = eg_cnt_q - CntOne;
      default: eg_cnt_d = eg_cnt_q;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      eg_wptr_q <= '0;
      eg_rptr_q <= '0;
      eg_cnt_q  <= '0;
    end else begin
      eg_wptr_q <= eg_wptr_d;
      eg_rptr_q <= eg_rptr_d;
      eg_cnt_q  <= eg_cnt_d;
    end
  end

  always_ff @(posedge clock) begin
    if (eg_push) begin
      eg_mem_q[eg_wptr_q] <= io_write_data;
    end
  end

  // ---------------------------------------------------------------------------
  // Protocol-violation flag
  // ---------------------------------------------------------------------------
`ifdef IO_PORT_FIFO_ERROR_EN
  logic error_q, error_d;
  logic violation;

  // A CPU strobe against a deasserted flag is a software bug; latch it until reset.
  assign violation = (io_rden & ~io_read_EF) | (io_wren & ~io_write_EF);
  assign error_d   = error_q | violation;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      error_q <= 1'b0;
    end else begin
      error_q <= error_d;
    end
  end

  assign error = error_q;
`else
  assign error = 1'b0;
`endif

endmodule

// File: tb/tb_io_port_fifo.sv
// Self-checking bench for io_port_fifo: directed scenarios plus random traffic, checked
// against queue-based models of both FIFOs.
module tb_io_port_fifo;

  localparam int unsigned WW    = 36;
  localparam int unsigned DEPTH = 4;

  logic          clock = 1'b0;
  logic          reset_n;
  logic          in_valid, in_ready;
  logic [WW-1:0] in_data, io_read_data;
  logic          io_read_EF, io_rden;
  logic [WW-1:0] io_write_data, out_data;
  logic          io_wren, io_write_EF, out_valid, out_ready, error;

  io_port_fifo #(
    .WORD_WIDTH(WW),
    .DEPTH     (DEPTH),
    .ADDR_WIDTH(2)
  ) dut (
    .clock        (clock),
    .reset_n      (reset_n),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_data      (in_data),
    .io_read_data (io_read_data),
    .io_read_EF   (io_read_EF),
    .io_rden      (io_rden),
    .io_write_data(io_write_data),
    .io_wren      (io_wren),
    .io_write_EF  (io_write_EF),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_data     (out_data),
    .error        (error)
  );

  always #5 clock = ~clock;

  int unsigned   n_checks = 0;
  int unsigned   n_errors = 0;
  logic [WW-1:0] in_q[$];
  logic [WW-1:0] eg_q[$];
  logic          err_m = 1'b0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_all();
    check_eq("in_ready", 64'(in_ready), 64'(in_q.size() < DEPTH));
    check_eq("io_read_EF", 64'(io_read_EF), 64'(in_q.size() != 0));
    if (in_q.size() != 0) check_eq("io_read_data", 64'(io_read_data), 64'(in_q[0]));
    check_eq("io_write_EF", 64'(io_write_EF), 64'(eg_q.size() < DEPTH));
    check_eq("out_valid", 64'(out_valid), 64'(eg_q.size() != 0));
    if (eg_q.size() != 0) check_eq("out_data", 64'(out_data), 64'(eg_q[0]));
    check_eq("error", 64'(error), 64'(err_m));
  endtask

  // Drive one cycle of inputs, advance the model across the edge, then check outputs.
  task automatic cyc(input logic iv, input logic [WW-1:0] id, input logic rd,
                     input logic wr, input logic [WW-1:0] wd, input logic ordy);
    bit in_push, in_pop, eg_push, eg_pop;
    in_valid = iv; in_data = id; io_rden = rd;
    io_wren = wr; io_write_data = wd; out_ready = ordy;
    @(posedge clock);
    in_push = iv && (in_q.size() < DEPTH);
    in_pop  = rd && (in_q.size() > 0);
    eg_push = wr && (eg_q.size() < DEPTH);
    eg_pop  = ordy && (eg_q.size() > 0);
`ifdef IO_PORT_FIFO_ERROR_EN
    if ((rd && in_q.size() == 0) || (wr && eg_q.size() == DEPTH)) err_m = 1'b1;
`endif
    if (in_pop) void'(in_q.pop_front());
    if (in_push) in_q.push_back(id);
    if (eg_pop) void'(eg_q.pop_front());
    if (eg_push) eg_q.push_back(wd);
    #1;
    check_all();
  endtask

  task automatic idle();
    cyc(1'b0, '0, 1'b0, 1'b0, '0, 1'b0);
  endtask

  initial begin
    in_valid = 0; in_data = '0; io_rden = 0; io_wren = 0; io_write_data = '0; out_ready = 0;
    reset_n = 1'b0;
    repeat (2) @(posedge clock);
    @(negedge clock);
    reset_n = 1'b1;
    #1;
    check_eq("rst_in_ready", 64'(in_ready), 64'd1);
    check_eq("rst_read_EF", 64'(io_read_EF), 64'd0);
    check_eq("rst_write_EF", 64'(io_write_EF), 64'd1);
    check_eq("rst_out_valid", 64'(out_valid), 64'd0);
    check_eq("rst_error", 64'(error), 64'd0);
    idle();

    // Ingress fill, overflow attempt, drain.
    for (int k = 1; k <= 4; k++) cyc(1'b1, WW'(k), 1'b0, 1'b0, '0, 1'b0);
    check_eq("ing_full_ready", 64'(in_ready), 64'd0);
    cyc(1'b1, WW'(5), 1'b0, 1'b0, '0, 1'b0);
    for (int k = 1; k <= 4; k++) begin
      check_eq("ing_drain_head", 64'(io_read_data), 64'(k));
      cyc(1'b0, '0, 1'b1, 1'b0, '0, 1'b0);
    end
    check_eq("ing_empty_EF", 64'(io_read_EF), 64'd0);

    // Steady push+pop at count 2; pointers wrap twice.
    cyc(1'b1, WW'('h11), 1'b0, 1'b0, '0, 1'b0);
    cyc(1'b1, WW'('h12), 1'b0, 1'b0, '0, 1'b0);
    for (int k = 0; k < 8; k++) begin
      check_eq("simul_head", 64'(io_read_data), 64'('h11 + k));
      cyc(1'b1, WW'('h13 + k), 1'b1, 1'b0, '0, 1'b0);
    end
    check_eq("simul_count2", 64'(in_q.size()), 64'd2);
    repeat (2) cyc(1'b0, '0, 1'b1, 1'b0, '0, 1'b0);

    // Egress fill, dropped write, drain.
    for (int k = 0; k < 4; k++) cyc(1'b0, '0, 1'b0, 1'b1, WW'('hA + k), 1'b0);
    check_eq("eg_full_EF", 64'(io_write_EF), 64'd0);
    cyc(1'b0, '0, 1'b0, 1'b1, WW'('hE), 1'b0);
    for (int k = 0; k < 4; k++) begin
      check_eq("eg_drain_head", 64'(out_data), 64'('hA + k));
      cyc(1'b0, '0, 1'b0, 1'b0, '0, 1'b1);
    end
    check_eq("eg_empty_valid", 64'(out_valid), 64'd0);

    // Illegal read while empty, then confirm the pointer did not move.
    cyc(1'b0, '0, 1'b1, 1'b0, '0, 1'b0);
    idle();
    cyc(1'b1, WW'('h77), 1'b0, 1'b0, '0, 1'b0);
    check_eq("illegal_rd_head", 64'(io_read_data), 64'('h77));
    cyc(1'b0, '0, 1'b1, 1'b0, '0, 1'b0);

    // Random traffic on both directions.
    for (int k = 0; k < 600; k++) begin
      cyc(1'($urandom_range(0, 1)), {4'($urandom), $urandom}, 1'($urandom_range(0, 1)),
          1'($urandom_range(0, 1)), {4'($urandom), $urandom}, 1'($urandom_range(0, 1)));
    end

    // Reset mid-operation with 3 words in each FIFO.
    while (in_q.size() > 0 || eg_q.size() > 0) cyc(1'b0, '0, 1'b1, 1'b0, '0, 1'b1);
    for (int k = 0; k < 3; k++) cyc(1'b1, WW'('h100 + k), 1'b0, 1'b1, WW'('h200 + k), 1'b0);
    check_eq("pre_rst_in_cnt", 64'(in_q.size()), 64'd3);
    #2;
    reset_n = 1'b0;
    #1;
    in_q.delete(); eg_q.delete(); err_m = 1'b0;
    check_eq("mid_rst_in_ready", 64'(in_ready), 64'd1);
    check_eq("mid_rst_read_EF", 64'(io_read_EF), 64'd0);
    check_eq("mid_rst_write_EF", 64'(io_write_EF), 64'd1);
    check_eq("mid_rst_out_valid", 64'(out_valid), 64'd0);
    check_eq("mid_rst_error", 64'(error), 64'd0);
    @(negedge clock);
    reset_n = 1'b1;
    repeat (3) idle();
    cyc(1'b1, WW'('h3C), 1'b0, 1'b1, WW'('h4C), 1'b0);
    check_eq("post_rst_in_head", 64'(io_read_data), 64'('h3C));
    check_eq("post_rst_eg_head", 64'(out_data), 64'('h4C));
    repeat (2) cyc(1'b0, '0, 1'b1, 1'b0, '0, 1'b1);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
